// File: rtl/key_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_encoder_pkg
//  Description : Shared widths, FSM state type, default debounce length and
//                the lowest-index priority encoder used by key_encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package key_encoder_pkg;

    localparam int KEY_W         = 8;
    localparam int CODE_W        = 3;
    localparam int DB_CYCLES_DEF = 50000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Lowest set bit wins; scanning from the top down lets the last hit stick.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [KEY_W-1:0] v);
        logic [CODE_W-1:0] enc;
        enc = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                enc = CODE_W'(i);
            end
        end
        return enc;
    endfunction

endpackage : key_encoder_pkg
`default_nettype wire

// File: rtl/key_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_encoder_if
//  Description : Key-event channel. The encoder (master) drives code/valid
//                plus the any_n level and drop pulse; the consumer (slave)
//                drives ready.
//  Ports       : code[2:0], valid, ready, any_n, drop
//  Revision    : 1.0  initial release
// ============================================================================
interface key_encoder_if;
    import key_encoder_pkg::*;

    logic [CODE_W-1:0] code;
    logic              valid;
    logic              ready;
    logic              any_n;
    logic              drop;

    modport master (
        output code,
        output valid,
        input  ready,
        output any_n,
        output drop
    );

    modport slave (
        input  code,
        input  valid,
        output ready,
        input  any_n,
        input  drop
    );

endinterface : key_encoder_if
`default_nettype wire

// File: rtl/key_encoder_debounce_vec.sv
`default_nettype none
// ============================================================================
//  Module      : key_encoder_debounce_vec
//  Description : Two-flop synchroniser per bit followed by a vector debouncer
//                sharing one counter. A new level is accepted once the whole
//                synchronised vector has held still for DB_CYCLES samples.
//  Ports       : clk, rst         clock / synchronous active-high reset
//                din_i[WIDTH]     asynchronous active-low lines
//                stable_o[WIDTH]  debounced vector
//  Revision    : 1.0  initial release
// ============================================================================
module key_encoder_debounce_vec #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] din_i,
    output logic      [WIDTH-1:0] stable_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] stable_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            cand_q   <= '1;
            stable_q <= '1;
            cnt_q    <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            // Any change anywhere in the vector restarts the shared count.
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;

endmodule : key_encoder_debounce_vec
`default_nettype wire

// File: rtl/key_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : key_encoder
//  Description : Debounces eight active-low key lines, detects new presses
//                and delivers the lowest newly pressed index over a
//                valid/ready channel, flagging events lost to backpressure.
//  Ports       : clk, rst     clock / synchronous active-high reset
//                pins_n[7:0]  asynchronous active-low key lines
//                evt          key_encoder_if master (code, valid, ready,
//                             any_n, drop)
//  Revision    : 1.0  initial release
// ============================================================================
module key_encoder
    import key_encoder_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [KEY_W-1:0] pins_n,
    key_encoder_if.master         evt
);

    logic [KEY_W-1:0]  stable_w;
    logic [KEY_W-1:0]  stable_prev_q;
    logic [KEY_W-1:0]  new_w;
    logic              event_w;
    logic [CODE_W-1:0] code_d;

    state_t            state_q;
    logic [CODE_W-1:0] code_q;
    logic              valid_q;
    logic              drop_q;
    logic              any_n_q;

    key_encoder_debounce_vec #(
        .WIDTH     (KEY_W),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .din_i    (pins_n),
        .stable_o (stable_w)
    );

    // Only 1->0 transitions of the debounced vector count as presses.
    assign new_w   = stable_prev_q & ~stable_w;
    assign event_w = |new_w;
    assign code_d  = prio_enc(new_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev_q <= '1;
            state_q       <= IDLE;
            code_q        <= '0;
            valid_q       <= 1'b0;
            drop_q        <= 1'b0;
            any_n_q       <= 1'b1;
        end else begin
            stable_prev_q <= stable_w;
            any_n_q       <= &stable_w;
            drop_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (event_w) begin
                        code_q  <= code_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (evt.ready) begin
                        // A press landing on the transfer cycle re-arms
                        // the channel instead of being lost.
                        if (event_w) begin
                            code_q <= code_d;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (event_w) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign evt.code  = code_q;
    assign evt.valid = valid_q;
    assign evt.drop  = drop_q;
    assign evt.any_n = any_n_q;

endmodule : key_encoder
`default_nettype wire

// File: tb/tb_key_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_encoder
//  Description : Self-checking bench for key_encoder with DB_CYCLES = 4.
//                Expected codes are queued when presses are driven and
//                popped whenever the DUT completes a valid/ready transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_encoder;

    localparam int DB = 4;
    localparam int LAT = DB + 3;   // edge index at which valid rises

    logic       clk;
    logic       rst;
    logic [7:0] pins_n;

    int n_vec;
    int n_err;
    int drop_cnt;
    logic pv;
    logic pr;
    logic [2:0] exp_q[$];

    key_encoder_if u_if ();

    key_encoder #(
        .DB_CYCLES (DB),
        .CNT_W     (16)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .pins_n (pins_n),
        .evt    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns with time at #1 after the edge where valid was first seen.
    task automatic wait_valid(input string tag, input int exp_edge);
        int e;
        e = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (u_if.valid) begin
                e = k;
                break;
            end
        end
        check_val(tag, e, exp_edge);
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    initial begin
        pv = 1'b0;
        pr = 1'b0;
        drop_cnt = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr) begin
                check_val("valid_hold", u_if.valid, 1);
            end
            if (u_if.drop) begin
                drop_cnt++;
                check_val("drop_in_hold", u_if.valid, 1);
            end
            if (u_if.valid && u_if.ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_event", {29'd0, u_if.code}, 32'hFFFF_FFFF);
                end else begin
                    check_val("event_code", {29'd0, u_if.code}, {29'd0, exp_q.pop_front()});
                end
            end
            pv = u_if.valid;
            pr = u_if.ready;
        end
    end

    initial begin
        int dbase;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        pins_n = 8'h00;
        u_if.ready = 1'b0;

        // Reset with every key held low.
        tick(3);
        check_val("rst_valid", u_if.valid, 0);
        check_val("rst_any_n", u_if.any_n, 1);
        check_val("rst_code", {29'd0, u_if.code}, 0);
        check_val("rst_drop", u_if.drop, 0);

        // Release reset: all-low vector is a press of every key -> code 0.
        u_if.ready = 1'b1;
        exp_q.push_back(3'd0);
        rst = 1'b0;
        wait_valid("rst_release_lat", LAT);
        check_val("rst_release_any_n", u_if.any_n, 0);
        pins_n = 8'hFF;
        tick(12);
        check_val("all_released_any_n", u_if.any_n, 1);

        // Single press of key 2.
        exp_q.push_back(3'd2);
        pins_n = 8'b1111_1011;
        wait_valid("single_lat", LAT);
        check_val("single_any_n", u_if.any_n, 0);
        tick(1);
        check_val("single_valid_fall", u_if.valid, 0);
        pins_n = 8'hFF;
        tick(12);
        check_val("single_release_any_n", u_if.any_n, 1);

        // Bounce on key 4, then settle low.
        for (int i = 0; i < 10; i++) begin
            pins_n = (i % 2 == 0) ? 8'hEF : 8'hFF;
            tick(2);
        end
        check_val("bounce_no_event", u_if.valid, 0);
        exp_q.push_back(3'd4);
        pins_n = 8'hEF;
        wait_valid("bounce_lat", LAT);
        pins_n = 8'hFF;
        tick(12);

        // Simultaneous keys 2 and 5: one event, lowest index.
        exp_q.push_back(3'd2);
        pins_n = 8'b1101_1011;
        wait_valid("simul_lat", LAT);
        tick(12);
        pins_n = 8'hFF;
        tick(12);

        // Backpressure: second press while first unconsumed is dropped.
        u_if.ready = 1'b0;
        dbase = drop_cnt;
        exp_q.push_back(3'd1);
        pins_n = 8'b1111_1101;
        wait_valid("bp_lat", LAT);
        pins_n = 8'hFF;
        tick(12);
        pins_n = 8'b1011_1111;
        tick(12);
        check_val("bp_drop_count", drop_cnt - dbase, 1);
        check_val("bp_valid", u_if.valid, 1);
        check_val("bp_code", {29'd0, u_if.code}, 1);
        u_if.ready = 1'b1;
        tick(1);
        check_val("bp_after_xfer", u_if.valid, 0);
        pins_n = 8'hFF;
        tick(12);

        // Back-to-back: new press lands on the transfer cycle.
        u_if.ready = 1'b0;
        dbase = drop_cnt;
        exp_q.push_back(3'd3);
        pins_n = 8'b1111_0111;
        wait_valid("b2b_first_lat", LAT);
        exp_q.push_back(3'd5);
        pins_n = 8'b1101_0111;
        tick(LAT);                  // stable updates on the last of these edges
        u_if.ready = 1'b1;
        tick(1);
        check_val("b2b_valid", u_if.valid, 1);
        check_val("b2b_code", {29'd0, u_if.code}, 5);
        check_val("b2b_no_drop", drop_cnt - dbase, 0);
        tick(1);
        check_val("b2b_final_valid", u_if.valid, 0);
        pins_n = 8'hFF;
        tick(12);

        check_val("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_key_encoder
`default_nettype wire

// File: doc/key_encoder.md
# key_encoder

Input-side counterpart of the 3-to-8 active-low digit-select decoder. Samples eight asynchronous, active-low button/key lines, synchronises and debounces them, detects new presses, and encodes the lowest newly pressed line into a 3-bit code delivered over a valid/ready handshake. Sits between board push-buttons and the control FSM or CSR logic that consumes key events.

## Interface

- `DB_CYCLES`, default 50000: stable-sample cycles needed to accept a new level (1 ms at 50 MHz); legal range 2..65535.
- `CNT_W`, default 16: debounce counter width; must hold `DB_CYCLES-1`.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `pins_n`  in  8  asynchronous active-low key lines; bit n low means key n pressed.
- `code`  out  3  encoded key index; bit n maps to n (8'b1111_1110 -> 3'b000, 8'b1111_1011 -> 3'b010, 8'b0111_1111 -> 3'b111).
- `valid`  out  1  `code` holds an unconsumed press event.
- `ready`  in  1  consumer accepts the event when `valid && ready`.
- `any_n`  out  1  debounced AND of all lines; low while any key is held.
- `drop`  out  1  one-cycle pulse: press event lost because the previous one was unconsumed.

## Operation

- Reset (synchronous, `rst`=1 at a rising edge): sync flops, candidate and stable registers = 8'hFF; counter = 0; FSM = IDLE; `code`=3'b000, `valid`=0, `any_n`=1, `drop`=0. Reset mid-event discards the pending event and any debounce in progress.
- Synchroniser: two flops per bit on `pins_n`, no logic between them.
- Debounce, one shared counter over the whole vector:
  - sync != cand: cand <= sync, cnt <= 0.
  - else if cnt == DB_CYCLES-1: stable <= cand; cnt holds.
  - else cnt <= cnt+1.
- Press detect: `new = stable_prev & ~stable` (bits going 1->0 on the stable update). Releases (0->1) generate no event. A held key never repeats.
- Encode: lowest set index of `new` (priority to bit 0). Simultaneous new presses of bits 2 and 5 yield one event with code 3'b010; bit 5 is not reported later.
- FSM:
  - IDLE: `valid`=0. On event: latch code, `valid`<=1, go HOLD.
  - HOLD: `valid`=1, `code` stable. On `ready`: if event in the same cycle, latch new code, stay HOLD; otherwise `valid`<=0, go IDLE. Event without `ready`: keep old code, pulse `drop`.
- `any_n` = AND-reduce of stable, registered.

## Timing

- A clean level change on `pins_n` first sampled at edge 0: sync output at edge 1, cand updated at edge 2, stable updated at edge DB_CYCLES+2, `valid`/`code` asserted after edge DB_CYCLES+3; `any_n` updates on the same edge.
- Any glitch shorter than DB_CYCLES cycles (as seen at the sync output) restarts the count; stable and outputs do not change.
- Handshake: transfer on rising edge where `valid && ready`; `valid` falls on that edge unless a simultaneous event re-arms it. `ready` with `valid`=0 is ignored. `valid` never drops without a transfer except on reset.
- `drop` high exactly one cycle per lost event; never asserted in IDLE.
- No combinational path from `ready` or `pins_n` to any output.

## Structure

- Shared package: `KEY_W` (8), `CODE_W` (3), FSM state typedef {IDLE, HOLD}, default `DB_CYCLES`.
- One natural sub-module: `debounce_vec` (synchroniser plus counter, parameterised by width and `DB_CYCLES`, outputs stable vector); the top holds edge detect, priority encoder and handshake FSM.

## Test plan

All with `DB_CYCLES`=4.
- Reset: hold `rst` 3 cycles with `pins_n`=8'h00 -> `valid`=0, `any_n`=1, `code`=0, `drop`=0; after release, press reported only after 7 edges.
- Single press: `pins_n` 8'hFF -> 8'b1111_1011, `ready`=1 -> `valid` one cycle with code 3'b010 at edge 7; `any_n` low; release gives no event.
- Bounce: toggle bit 4 every 2 cycles for 20 cycles, then hold low -> exactly one event, code 3'b100, 7 edges after final transition.
- Simultaneous press: 8'hFF -> 8'b1101_1011 -> one event code 3'b010; no second event.
- Backpressure: `ready`=0, press key 1, release, press key 6 -> `valid` holds code 3'b001, `drop` pulses once; raising `ready` transfers 3'b001, then `valid`=0.
- Back-to-back: event arrives on the cycle of a `valid&&ready` transfer -> `valid` stays high, `code` updates to new value, no `drop`.
